// File: rtl/mem_bus_fabric.sv
// mem_bus_fabric: address decoder, read mux and transaction tracker between
// the FemtoRV32 core and NUM_SLAVES memory-mapped slaves. Slave 0 is the
// default target; slaves 1..NUM_SLAVES-1 occupy consecutive 64 KiB pages
// starting at BASE_PAGE. A watchdog aborts transactions whose slave stays
// busy for TIMEOUT cycles and records the failure in sticky error registers.
module mem_bus_fabric #(
  parameter int          NUM_SLAVES = 7,
  parameter logic [15:0] BASE_PAGE  = 16'h0040,
  parameter int          TIMEOUT    = 255,
  parameter logic [31:0] ERR_DATA   = 32'h6666_6666
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [31:0]             mem_addr,
  input  logic                    mem_rstrb,
  input  logic [3:0]              mem_wmask,
  output logic [31:0]             mem_rdata,
  output logic                    mem_rbusy,
  output logic                    mem_wbusy,
  output logic [NUM_SLAVES-1:0]   s_cs,
  output logic                    s_rd,
  output logic                    s_wr,
  input  logic [32*NUM_SLAVES-1:0] s_rdata,
  input  logic [NUM_SLAVES-1:0]   s_rbusy,
  input  logic [NUM_SLAVES-1:0]   s_wbusy,
  input  logic                    err_clr,
  output logic                    bus_err,
  output logic [31:0]             err_addr,
  output logic [7:0]              err_count
);

  localparam int SEL_W = $clog2(NUM_SLAVES);
  // Counter must be able to reach TIMEOUT itself, since expiry is cnt == TIMEOUT.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
  localparam logic [16:0]      LAST_OFF = 17'(NUM_SLAVES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [31:0]        addr_q, addr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;
  logic               bus_err_q, bus_err_d;
  logic [31:0]        err_addr_q, err_addr_d;
  logic [7:0]         err_count_q, err_count_d;

  logic [16:0]        page_off;
  logic               in_range;
  logic [SEL_W-1:0]   index;
  logic               sel_rbusy, sel_wbusy;
  logic               expire;
  logic               strobe;
  logic               accept;
  logic               abort;

  // Page decode: pages outside the peripheral window fall back to slave 0.
  // The 17-bit subtraction keeps pages below BASE_PAGE from wrapping into range.
  assign page_off = {1'b0, mem_addr[31:16]} - {1'b0, BASE_PAGE};
  assign in_range = (mem_addr[31:16] >= BASE_PAGE) && (page_off < LAST_OFF);
  assign index    = in_range ? (SEL_W'(page_off) + SEL_W'(1)) : '0;

  // One-hot chip select, purely combinational from the current address.
  always_comb begin
    s_cs        = '0;
    s_cs[index] = 1'b1;
  end

  // Strobes go to all slaves; each slave qualifies them with its own s_cs bit.
  assign s_rd = mem_rstrb;
  assign s_wr = |mem_wmask;

  assign sel_rbusy = s_rbusy[sel_q];
  assign sel_wbusy = s_wbusy[sel_q];

  // Watchdog fires only while a transaction is outstanding.
  assign expire = (TIMEOUT != 0) && (state_q != IDLE) && (cnt_q == CNT_MAX);

  assign mem_rbusy = (state_q == RD_WAIT) && sel_rbusy && !expire;
  assign mem_wbusy = (state_q == WR_WAIT) && sel_wbusy && !expire;

  assign strobe = mem_rstrb || (|mem_wmask);
  assign accept = strobe && !mem_rbusy && !mem_wbusy;

  // Read data: error pattern on an aborted read, else the tracked slave's data.
  assign mem_rdata = ((expire && (state_q == RD_WAIT)) || err_q)
                     ? ERR_DATA : s_rdata[{sel_q, 5'b00000} +: 32];

  assign bus_err   = bus_err_q;
  assign err_addr  = err_addr_q;
  assign err_count = err_count_q;

  // Next-state logic: transaction tracking, watchdog and error bookkeeping.
  // NOTE: every _d gets its hold value first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    bus_err_d   = bus_err_q;
    err_addr_d  = err_addr_q;
    err_count_d = err_count_q;
    abort       = 1'b0;

    unique case (state_q)
      RD_WAIT: begin
        if (expire) begin
          abort   = 1'b1;
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (sel_rbusy) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          state_d = IDLE;
        end
      end
      WR_WAIT: begin
        if (expire) begin
          abort   = 1'b1;
          state_d = IDLE;
        end else if (sel_wbusy) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          state_d = IDLE;
        end
      end
      default: ;
    endcase

    // A new strobe starts a fresh transaction; a write wins over a read.
    if (accept) begin
      sel_d   = index;
      addr_d  = mem_addr;
      cnt_d   = '0;
      err_d   = 1'b0;
      state_d = (|mem_wmask) ? WR_WAIT : RD_WAIT;
    end

    // An abort in the same cycle as err_clr takes precedence over the clear.
    if (abort) begin
      bus_err_d = 1'b1;
      if (!bus_err_q) begin
        err_addr_d = addr_q;
      end
      if (err_count_q != 8'hFF) begin
        err_count_d = err_count_q + 8'd1;
      end
    end else if (err_clr) begin
      bus_err_d  = 1'b0;
      err_addr_d = '0;
    end
  end

  // State registers; reset drops any transaction in flight at once.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      addr_q      <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      bus_err_q   <= 1'b0;
      err_addr_q  <= '0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      bus_err_q   <= bus_err_d;
      err_addr_q  <= err_addr_d;
      err_count_q <= err_count_d;
    end
  end

endmodule

// File: tb/tb_mem_bus_fabric.sv
// Directed bench for mem_bus_fabric: one instance with TIMEOUT=8 for decode,
// read/write timing and read aborts, a second with TIMEOUT=4 for the error
// counter saturation and err_clr behaviour. Both share the bus inputs.
module tb_mem_bus_fabric;

  localparam int NS = 7;

  logic              clk;
  logic              resetn;
  logic [31:0]       mem_addr;
  logic              mem_rstrb;
  logic [3:0]        mem_wmask;
  logic [NS-1:0]     s_rbusy;
  logic [NS-1:0]     s_wbusy;
  logic              err_clr;
  logic [31:0]       sdat [NS];
  logic [32*NS-1:0]  s_rdata;

  logic [31:0]   dut_rdata, u4_rdata;
  logic          dut_rbusy, u4_rbusy;
  logic          dut_wbusy, u4_wbusy;
  logic [NS-1:0] dut_cs, u4_cs;
  logic          dut_rd, u4_rd;
  logic          dut_wr, u4_wr;
  logic          dut_bus_err, u4_bus_err;
  logic [31:0]   dut_err_addr, u4_err_addr;
  logic [7:0]    dut_err_count, u4_err_count;

  int n_checks = 0;
  int n_errors = 0;

  mem_bus_fabric #(.NUM_SLAVES(NS), .BASE_PAGE(16'h0040), .TIMEOUT(8),
                   .ERR_DATA(32'h6666_6666)) dut (
    .clk(clk), .resetn(resetn), .mem_addr(mem_addr), .mem_rstrb(mem_rstrb),
    .mem_wmask(mem_wmask), .mem_rdata(dut_rdata), .mem_rbusy(dut_rbusy),
    .mem_wbusy(dut_wbusy), .s_cs(dut_cs), .s_rd(dut_rd), .s_wr(dut_wr),
    .s_rdata(s_rdata), .s_rbusy(s_rbusy), .s_wbusy(s_wbusy), .err_clr(err_clr),
    .bus_err(dut_bus_err), .err_addr(dut_err_addr), .err_count(dut_err_count)
  );

  mem_bus_fabric #(.NUM_SLAVES(NS), .BASE_PAGE(16'h0040), .TIMEOUT(4),
                   .ERR_DATA(32'h6666_6666)) u4 (
    .clk(clk), .resetn(resetn), .mem_addr(mem_addr), .mem_rstrb(mem_rstrb),
    .mem_wmask(mem_wmask), .mem_rdata(u4_rdata), .mem_rbusy(u4_rbusy),
    .mem_wbusy(u4_wbusy), .s_cs(u4_cs), .s_rd(u4_rd), .s_wr(u4_wr),
    .s_rdata(s_rdata), .s_rbusy(s_rbusy), .s_wbusy(s_wbusy), .err_clr(err_clr),
    .bus_err(u4_bus_err), .err_addr(u4_err_addr), .err_count(u4_err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pack the per-slave data words onto the flat slave data bus.
  always_comb begin
    for (int k = 0; k < NS; k++) s_rdata[32*k +: 32] = sdat[k];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 ns after a rising edge; outputs are sampled on the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic mid_cycle();
    @(negedge clk);
  endtask

  function automatic logic [31:0] slave_addr(input int k);
    if (k == 0) return 32'h0000_0100;
    return {16'h0040 + 16'(k - 1), 16'h0000};
  endfunction

  initial begin
    resetn    = 1'b0;
    mem_addr  = '0;
    mem_rstrb = 1'b0;
    mem_wmask = '0;
    s_rbusy   = '0;
    s_wbusy   = '0;
    err_clr   = 1'b0;
    for (int k = 0; k < NS; k++) sdat[k] = 32'hA000_0000 | 32'(k);

    // Reset values.
    repeat (2) @(posedge clk);
    mid_cycle();
    check("rst_rbusy",     32'(dut_rbusy),     32'd0);
    check("rst_wbusy",     32'(dut_wbusy),     32'd0);
    check("rst_bus_err",   32'(dut_bus_err),   32'd0);
    check("rst_err_addr",  dut_err_addr,       32'd0);
    check("rst_err_count", 32'(dut_err_count), 32'd0);
    check("rst_rdata",     dut_rdata,          32'hA000_0000);
    next_cycle();
    resetn = 1'b1;

    // Decode sweep, no strobes.
    mem_addr = 32'h0040_0000; #1;
    check("dec_0040", 32'(dut_cs), 32'h02);
    mem_addr = 32'h0045_0010; #1;
    check("dec_0045", 32'(dut_cs), 32'h40);
    mem_addr = 32'h0046_0000; #1;
    check("dec_0046", 32'(dut_cs), 32'h01);
    mem_addr = 32'h0000_1234; #1;
    check("dec_low",  32'(dut_cs), 32'h01);
    check("idle_s_rd", 32'(dut_rd), 32'd0);
    next_cycle();

    // Back-to-back zero-wait reads of slaves 0..6; data of read i-1 in cycle i.
    for (int i = 0; i <= NS; i++) begin
      if (i < NS) begin
        mem_addr  = slave_addr(i);
        mem_rstrb = 1'b1;
      end else begin
        mem_rstrb = 1'b0;
      end
      mid_cycle();
      if (i < NS) begin
        check("b2b_s_rd", 32'(dut_rd), 32'd1);
        check("b2b_s_cs", 32'(dut_cs), 32'(1) << i);
      end
      if (i > 0) check("b2b_rdata", dut_rdata, 32'hA000_0000 | 32'(i - 1));
      check("b2b_rbusy", 32'(dut_rbusy), 32'd0);
      next_cycle();
    end

    // Slave 0 busy for 5 cycles; a strobe to slave 5 mid-stall must be ignored.
    mem_addr  = slave_addr(0);
    mem_rstrb = 1'b1;
    next_cycle();
    mem_rstrb = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      s_rbusy[0] = (c <= 5);
      if (c == 2) begin
        mem_addr  = slave_addr(5);
        mem_rstrb = 1'b1;
      end else begin
        mem_rstrb = 1'b0;
      end
      if (c == 6) sdat[0] = 32'h1234_5678;
      mid_cycle();
      check("wait5_rbusy", 32'(dut_rbusy), 32'(c <= 5));
      if (c == 6) begin
        check("wait5_rdata",   dut_rdata,         32'h1234_5678);
        check("wait5_bus_err", 32'(dut_bus_err),  32'd0);
      end
      next_cycle();
    end
    sdat[0] = 32'hA000_0000;

    // Simultaneous read and write strobes: the write wins, slave 2 write busy 2 cycles.
    mem_addr  = slave_addr(2);
    mem_rstrb = 1'b1;
    mem_wmask = 4'hF;
    s_rbusy[2] = 1'b1;
    s_wbusy[2] = 1'b1;
    mid_cycle();
    check("wr_s_wr", 32'(dut_wr), 32'd1);
    check("wr_s_rd", 32'(dut_rd), 32'd1);
    next_cycle();
    mem_rstrb = 1'b0;
    mem_wmask = '0;
    for (int c = 1; c <= 3; c++) begin
      s_wbusy[2] = (c <= 2);
      mid_cycle();
      check("wr_wbusy", 32'(dut_wbusy), 32'(c <= 2));
      check("wr_rbusy", 32'(dut_rbusy), 32'd0);
      next_cycle();
    end
    s_rbusy[2] = 1'b0;

    // Slave 3 stuck busy on a read: 8 stall cycles, then the abort.
    mem_addr   = 32'h0042_0004;
    mem_rstrb  = 1'b1;
    s_rbusy[3] = 1'b1;
    next_cycle();
    mem_rstrb = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      mid_cycle();
      check("to_rbusy", 32'(dut_rbusy), 32'(c <= 8));
      if (c == 9) begin
        check("to_expire_rdata",   dut_rdata,        32'h6666_6666);
        check("to_expire_bus_err", 32'(dut_bus_err), 32'd0);
      end
      next_cycle();
    end
    mid_cycle();
    check("to_bus_err",   32'(dut_bus_err),   32'd1);
    check("to_err_addr",  dut_err_addr,       32'h0042_0004);
    check("to_err_count", 32'(dut_err_count), 32'd1);
    check("to_rdata_hold", dut_rdata,         32'h6666_6666);
    s_rbusy[3] = 1'b0;
    mem_addr   = slave_addr(1);
    mem_rstrb  = 1'b1;
    next_cycle();
    mem_rstrb = 1'b0;
    mid_cycle();
    check("after_to_rdata",   dut_rdata,        32'hA000_0001);
    check("after_to_bus_err", 32'(dut_bus_err), 32'd1);
    check("after_to_rbusy",   32'(dut_rbusy),   32'd0);
    next_cycle();

    // Reset pulsed during RD_WAIT: busy drops immediately, next read is clean.
    mem_addr   = slave_addr(3);
    mem_rstrb  = 1'b1;
    s_rbusy[3] = 1'b1;
    next_cycle();
    mem_rstrb = 1'b0;
    next_cycle();
    mid_cycle();
    check("pre_rst_rbusy", 32'(dut_rbusy), 32'd1);
    resetn = 1'b0;
    #1;
    check("async_rst_rbusy",   32'(dut_rbusy),   32'd0);
    check("async_rst_bus_err", 32'(dut_bus_err), 32'd0);
    next_cycle();
    resetn     = 1'b1;
    s_rbusy[3] = 1'b0;
    mem_addr   = slave_addr(4);
    mem_rstrb  = 1'b1;
    next_cycle();
    mem_rstrb = 1'b0;
    mid_cycle();
    check("post_rst_rdata", dut_rdata,      32'hA000_0004);
    check("post_rst_rbusy", 32'(dut_rbusy), 32'd0);
    next_cycle();

    // TIMEOUT=4 instance: stuck write to slave 1, first abort in detail.
    mem_addr   = 32'h0040_0008;
    mem_wmask  = 4'h1;
    s_wbusy[1] = 1'b1;
    next_cycle();
    mem_wmask = '0;
    for (int c = 1; c <= 5; c++) begin
      mid_cycle();
      check("wto_wbusy", 32'(u4_wbusy), 32'(c <= 4));
      if (c == 5) check("wto_pre_bus_err", 32'(u4_bus_err), 32'd0);
      next_cycle();
    end
    mid_cycle();
    check("wto_bus_err",   32'(u4_bus_err),   32'd1);
    check("wto_err_addr",  u4_err_addr,       32'h0040_0008);
    check("wto_err_count", 32'(u4_err_count), 32'd1);
    check("wto_rdata",     u4_rdata,          32'hA000_0001);

    // 299 further aborts drive the counter past saturation (300 total).
    for (int j = 0; j < 299; j++) begin
      mem_wmask = 4'h1;
      next_cycle();
      mem_wmask = '0;
      repeat (5) next_cycle();
    end
    mid_cycle();
    check("sat_err_count", 32'(u4_err_count), 32'd255);
    check("sat_bus_err",   32'(u4_bus_err),   32'd1);
    check("sat_err_addr",  u4_err_addr,       32'h0040_0008);

    // err_clr clears flag and address but leaves the counter.
    err_clr = 1'b1;
    next_cycle();
    err_clr = 1'b0;
    mid_cycle();
    check("clr_bus_err",   32'(u4_bus_err),   32'd0);
    check("clr_err_addr",  u4_err_addr,       32'd0);
    check("clr_err_count", 32'(u4_err_count), 32'd255);

    // err_clr coinciding with an abort: the abort wins.
    mem_addr  = 32'h0040_00AC;
    mem_wmask = 4'h1;
    next_cycle();
    mem_wmask = '0;
    repeat (4) next_cycle();
    err_clr = 1'b1;
    mid_cycle();
    check("race_expire_wbusy", 32'(u4_wbusy), 32'd0);
    next_cycle();
    err_clr = 1'b0;
    mid_cycle();
    check("race_bus_err",   32'(u4_bus_err),   32'd1);
    check("race_err_addr",  u4_err_addr,       32'h0040_00AC);
    check("race_err_count", 32'(u4_err_count), 32'd255);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_bus_fabric.md
# mem_bus_fabric

Parametrised memory-bus interconnect between the FemtoRV32 core and N memory-mapped slaves (slave 0 = program memory/mapped SPI flash, slaves 1..N-1 = peripherals). It replaces the fixed one-hot chip-select decoder and read mux with a decoder whose slave count is a parameter. It also adds:
- a registered transaction tracker that forwards per-slave read/write busy to the CPU;
- a watchdog that aborts stalled transactions;
- sticky error reporting.

## Interface
- NUM_SLAVES, 7: slave count, 2..16; slave 0 is the default target.
- BASE_PAGE, 16'h0040: mem_addr[31:16] page of slave 1; slave k at BASE_PAGE+k-1.
- TIMEOUT, 255: max busy cycles before abort; 0 disables watchdog.
- ERR_DATA, 32'h66666666: read data returned for an aborted read.
- clk  in  1  system clock; all state on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- mem_addr  in  32  CPU byte address.
- mem_rstrb  in  1  CPU read strobe, one cycle.
- mem_wmask  in  4  CPU byte write mask; nonzero = write strobe.
- mem_rdata  out  32  read data to CPU.
- mem_rbusy  out  1  read stall to CPU.
- mem_wbusy  out  1  write stall to CPU.
- s_cs  out  NUM_SLAVES  one-hot combinational decode of mem_addr.
- s_rd  out  1  mem_rstrb, qualified per slave by s_cs.
- s_wr  out  1  |mem_wmask, qualified per slave by s_cs.
- s_rdata  in  32*NUM_SLAVES  slave k data on bits [32k+31:32k].
- s_rbusy  in  NUM_SLAVES  per-slave read busy.
- s_wbusy  in  NUM_SLAVES  per-slave write busy.
- err_clr  in  1  clears bus_err and err_addr (not err_count).
- bus_err  out  1  sticky: a watchdog abort occurred.
- err_addr  out  32  mem_addr of first abort since last clear.
- err_count  out  8  saturating abort counter (saturates at 255).

## Operation
- Decode: page = mem_addr[31:16]. If BASE_PAGE <= page <= BASE_PAGE+NUM_SLAVES-2, index = page-BASE_PAGE+1; else index = 0. s_cs = one-hot(index), purely combinational.
- States: IDLE, RD_WAIT, WR_WAIT. Registers: sel_q (index), addr_q, cnt (width to hold TIMEOUT), err_q.
- Accept: a strobe is accepted in any cycle where mem_rbusy=0 and mem_wbusy=0. On accept:
  - sel_q <= index, addr_q <= mem_addr, cnt <= 0, err_q <= 0.
  - Next state is WR_WAIT if wmask != 0, else RD_WAIT.
  - Write has priority if both strobes are asserted.
- Strobe during a stall: ignored; the FSM does not change state.
- RD_WAIT:
  - mem_rbusy = s_rbusy[sel_q] & ~expire, where expire = (TIMEOUT != 0) & (cnt == TIMEOUT).
  - If s_rbusy[sel_q]=0: go to IDLE, or accept a new strobe that same cycle.
  - Otherwise cnt <= cnt+1.
  - On expire: abort (below) and go to IDLE.
- WR_WAIT: same rules using s_wbusy/mem_wbusy.
- mem_rdata = ERR_DATA when (expire in RD_WAIT) or err_q; otherwise s_rdata[sel_q]. The value holds until the next accept.
- Abort:
  - err_q <= 1 for reads only.
  - bus_err <= 1; err_addr <= addr_q if bus_err was 0.
  - err_count increments, saturating.
- err_clr is ignored if it coincides with an abort; the abort wins.
- Reset asserted mid-transaction: returns to IDLE immediately. The slave's own state is not touched.

## Timing
- Reset values: state IDLE, sel_q 0, addr_q 0, cnt 0, err_q 0, bus_err 0, err_addr 0, err_count 0, mem_rbusy 0, mem_wbusy 0. mem_rdata follows s_rdata[0].
- s_cs, s_rd, s_wr: zero latency from mem_addr and the strobes.
- Busy is first visible the cycle after the strobe. A zero-wait slave completes in 1 cycle, allowing back-to-back strobes every cycle.
- A slave busy for B cycles (B < TIMEOUT) stalls the CPU exactly B cycles; data is valid in the first non-busy cycle.
- A permanently busy slave stalls the CPU exactly TIMEOUT cycles. Busy drops in cycle TIMEOUT+1 after the strobe, and bus_err rises on the following edge.

## Test plan
- Decode sweep: addr 0x0040_0000 -> s_cs=7'b0000010; 0x0045_0010 -> 7'b1000000; 0x0046_0000 and 0x0000_1234 -> 7'b0000001.
- Zero-wait reads to slaves 0..6 on consecutive cycles, slave k returning 32'hA000_000k -> mem_rdata matches each, mem_rbusy never 1.
- Slave 0 rbusy held 5 cycles -> mem_rbusy high exactly 5 cycles; data captured in cycle 6; bus_err stays 0.
- Slave 3 rbusy stuck, TIMEOUT=8, read 0x0042_0004 -> rbusy high 8 cycles, then mem_rdata=32'h66666666, bus_err=1, err_addr=0x0042_0004, err_count=1; next normal read clears ERR_DATA.
- Stuck write: 300 aborts with TIMEOUT=4 -> err_count=255; err_clr -> bus_err=0, err_addr=0, err_count stays 255.
- resetn pulsed low during RD_WAIT -> mem_rbusy 0 asynchronously, state IDLE; the next read completes normally.
